// File: rtl/apu_pkg.sv
// Shared APU definitions: power-sequencer state encoding and NR52 layout constants.
package apu_pkg;

   // Upper bound on channels any APU instance may control
   localparam int unsigned APU_MAX_CHANNELS = 8;

   // Bit position of the master power-enable within NR52
   localparam int unsigned NR52_MASTER_BIT = 7;

   // Power sequencer states
   typedef enum logic [1:0] {
      PWR_OFF,
      PWR_UP,
      PWR_ON,
      PWR_CLEAR
   } pwr_state_t;

endpackage

// File: rtl/apu_chan_status.sv
// Per-channel active-status flops.
// A trigger sets a bit and a stop clears it, with the trigger winning on a tie.
// The synchronous clear overrides both, and enable gates all set/stop updates.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   enable        - accept trigger/stop updates this cycle
//   clear         - synchronously zero all status bits
//   trigger, stop - per-channel set / clear pulses
//   status        - registered channel-active bits
module apu_chan_status #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] trigger,
   input  logic [WIDTH-1:0] stop,
   output logic [WIDTH-1:0] status
);

   // Status register; the trigger term is ORed in after the stop mask so a trigger beats a same-cycle stop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         status <= '0;
      end else if (clear) begin
         status <= '0;
      end else if (enable) begin
         status <= (status & ~stop) | trigger;
      end
   end

endmodule

// File: rtl/apu_power_seq.sv
// APU power sequencer.
// Tracks the NR52 master enable and, on power-up, drives timed per-channel reset pulses.
// On power-down it drives a timed register-file clear. Register writes are gated
// while the APU is unpowered, and the per-channel active bits are maintained here.
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   pwr_wr, pwr_wdata   - write strobe / value for the master-enable bit
//   chan_trigger        - per-channel trigger pulses
//   chan_stop           - per-channel stop pulses
//   chan_reset          - per-channel reset, held RESET_CYCLES after power-up
//   regs_clear          - register-file clear, held CLEAR_CYCLES after power-down
//   write_allow         - non-NR52 register writes permitted
//   powered             - master-enable readback
//   status              - channel-active readback
module apu_power_seq
   import apu_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned RESET_CYCLES = 1,
   parameter int unsigned CLEAR_CYCLES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    pwr_wr,
   input  logic                    pwr_wdata,
   input  logic [NUM_CHANNELS-1:0] chan_trigger,
   input  logic [NUM_CHANNELS-1:0] chan_stop,
   output logic [NUM_CHANNELS-1:0] chan_reset,
   output logic                    regs_clear,
   output logic                    write_allow,
   output logic                    powered,
   output logic [NUM_CHANNELS-1:0] status
);

   localparam int unsigned MAX_CYCLES = (RESET_CYCLES > CLEAR_CYCLES) ? RESET_CYCLES : CLEAR_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

   pwr_state_t       state, state_nxt;
   logic [CNT_W-1:0] counter, counter_nxt;
   logic             pending_on, pending_nxt;
   logic             pend_eff;
   logic             wr_on, wr_off;
   logic             status_enable, status_clear;

   assign wr_on  = pwr_wr &  pwr_wdata;
   assign wr_off = pwr_wr & ~pwr_wdata;

   // State, counter and output registers; outputs are decoded from the next state so they align with it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= PWR_OFF;
         counter     <= '0;
         pending_on  <= 1'b0;
         chan_reset  <= '0;
         regs_clear  <= 1'b0;
         write_allow <= 1'b0;
         powered     <= 1'b0;
      end else begin
         state       <= state_nxt;
         counter     <= counter_nxt;
         pending_on  <= pending_nxt;
         chan_reset  <= (state_nxt == PWR_UP) ? '1 : '0;
         regs_clear  <= (state_nxt == PWR_CLEAR);
         write_allow <= (state_nxt == PWR_ON);
         powered     <= (state_nxt == PWR_UP) || (state_nxt == PWR_ON);
      end
   end

   // Next-state logic; the counter only counts down and is reloaded on state entry
   always_comb begin
      state_nxt   = state;
      counter_nxt = (counter != '0) ? counter - CNT_W'(1) : counter;
      pending_nxt = pending_on;
      pend_eff    = pending_on;

      case (state)
         PWR_OFF: begin
            if (wr_on) begin
               state_nxt   = PWR_UP;
               counter_nxt = RST_LOAD;
            end
         end
         PWR_UP: begin
            if (wr_off) begin
               state_nxt   = PWR_CLEAR;
               counter_nxt = CLR_LOAD;
               pending_nxt = 1'b0;
            end else if (counter == '0) begin
               state_nxt = PWR_ON;
            end
         end
         PWR_ON: begin
            if (wr_off) begin
               state_nxt   = PWR_CLEAR;
               counter_nxt = CLR_LOAD;
               pending_nxt = 1'b0;
            end
         end
         PWR_CLEAR: begin
            // A write in the final clear cycle still decides where the sequencer goes next
            pend_eff    = pwr_wr ? pwr_wdata : pending_on;
            pending_nxt = pend_eff;
            if (counter == '0) begin
               pending_nxt = 1'b0;
               if (pend_eff) begin
                  state_nxt   = PWR_UP;
                  counter_nxt = RST_LOAD;
               end else begin
                  state_nxt = PWR_OFF;
               end
            end
         end
         default: begin
            state_nxt = PWR_OFF;
         end
      endcase
   end

   // Channel updates are only honoured while fully on; leaving ON wipes status on the same edge
   assign status_enable = (state == PWR_ON);
   assign status_clear  = (state_nxt != PWR_ON);

   apu_chan_status #(
      .WIDTH (NUM_CHANNELS)
   ) u_chan_status (
      .clock   (clock),
      .reset   (reset),
      .enable  (status_enable),
      .clear   (status_clear),
      .trigger (chan_trigger),
      .stop    (chan_stop),
      .status  (status)
   );

endmodule

// File: tb/tb_apu_power_seq.sv
// Bench for apu_power_seq with NUM_CHANNELS=4, RESET_CYCLES=3, CLEAR_CYCLES=2.
module tb_apu_power_seq;

   logic       clock;
   logic       reset;
   logic       pwr_wr;
   logic       pwr_wdata;
   logic [3:0] chan_trigger;
   logic [3:0] chan_stop;
   logic [3:0] chan_reset;
   logic       regs_clear;
   logic       write_allow;
   logic       powered;
   logic [3:0] status;

   apu_power_seq #(
      .NUM_CHANNELS (4),
      .RESET_CYCLES (3),
      .CLEAR_CYCLES (2)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .pwr_wr       (pwr_wr),
      .pwr_wdata    (pwr_wdata),
      .chan_trigger (chan_trigger),
      .chan_stop    (chan_stop),
      .chan_reset   (chan_reset),
      .regs_clear   (regs_clear),
      .write_allow  (write_allow),
      .powered      (powered),
      .status       (status)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Observed bundle: {chan_reset, regs_clear, write_allow, powered, status}
   typedef logic [10:0] obs_t;

   typedef struct {
      logic       wr;
      logic       wd;
      logic [3:0] tr;
      logic [3:0] sp;
      obs_t       exp;
   } vec_t;

   vec_t vecs[$];
   obs_t exp_q[$];
   int   n_vec;
   int   n_bad;

   function automatic vec_t mk(input logic wr, input logic wd, input logic [3:0] tr,
                               input logic [3:0] sp, input logic [3:0] cr, input logic rc,
                               input logic wa, input logic pw, input logic [3:0] st);
      vec_t v;
      v.wr  = wr;
      v.wd  = wd;
      v.tr  = tr;
      v.sp  = sp;
      v.exp = {cr, rc, wa, pw, st};
      return v;
   endfunction

   function automatic obs_t observe();
      return {chan_reset, regs_clear, write_allow, powered, status};
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t got;
      got = observe();
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got cr=%b rc=%b wa=%b pw=%b st=%b, want cr=%b rc=%b wa=%b pw=%b st=%b",
                  name, got[10:7], got[6], got[5], got[4], got[3:0],
                  exp[10:7], exp[6], exp[5], exp[4], exp[3:0]);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare just after the sampling edge
   task automatic apply(input int idx, input vec_t v);
      obs_t e;
      @(negedge clock);
      pwr_wr       = v.wr;
      pwr_wdata    = v.wd;
      chan_trigger = v.tr;
      chan_stop    = v.sp;
      exp_q.push_back(v.exp);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", idx), e);
   endtask

   initial begin
      n_vec        = 0;
      n_bad        = 0;
      reset        = 1'b1;
      pwr_wr       = 1'b0;
      pwr_wdata    = 1'b0;
      chan_trigger = '0;
      chan_stop    = '0;

      //                wr  wd  trig     stop     cr       rc wa pw status
      vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000)); // OFF ignores triggers
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000)); // power up, reset cycle 1
      vecs.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000)); // reset cycle 2, trigger ignored
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000)); // reset cycle 3
      vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 1, 4'b0000)); // ON; trigger in last reset cycle ignored
      vecs.push_back(mk(0, 0, 4'b0101, 4'b0000, 4'b0000, 0, 1, 1, 4'b0101)); // trigger 0101
      vecs.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 1, 1, 4'b0101)); // trigger beats stop
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0100, 4'b0000, 0, 1, 1, 4'b0001)); // stop ch2
      vecs.push_back(mk(0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 1, 1, 4'b0011)); // status 0011
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 4'b0011)); // power-on write while ON: no re-reset
      vecs.push_back(mk(1, 0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000)); // power down beats trigger
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000)); // clear cycle 2
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000)); // OFF
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000)); // power up again
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 4'b0000)); // ON
      vecs.push_back(mk(0, 0, 4'b0011, 4'b0000, 4'b0000, 0, 1, 1, 4'b0011));
      vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000)); // power down
      vecs.push_back(mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000)); // power-on write in first clear cycle
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000)); // pending power-up taken
      vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000)); // abort in first reset cycle
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000)); // OFF, never reached ON
      vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000)); // power-off write in OFF
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 4'b0000));
      vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000)); // power down
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000)); // set pending
      vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000)); // cancel pending in last clear cycle

      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset_state", 11'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(i, vecs[i]);
      end

      // Async reset in the middle of a reset pulse
      apply(100, mk(1, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      apply(101, mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_pwrup", 11'b0);
      @(negedge clock);
      reset = 1'b0;
      apply(102, mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000)); // back in OFF, no pulse continuation

      // Async reset during a register clear with live status beforehand
      apply(103, mk(1, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      apply(104, mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      apply(105, mk(0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000));
      apply(106, mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 4'b0000));
      apply(107, mk(0, 0, 4'b1001, 4'b0000, 4'b0000, 0, 1, 1, 4'b1001));
      apply(108, mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_clear", 11'b0);
      @(negedge clock);
      reset = 1'b0;
      apply(109, mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
